div_unit: RTL and testbench

DIV_UNIT -- requirements
Module: div_unit

---
 rtl/div_unit.sv | 175 +++++++++++++++++
 tb/tb_div_unit.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | div_unit : multi-cycle radix-4 restoring divider, signed and unsigned,   |
// |            with zero-divisor detection, cancel and asynchronous reset.   |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             cpu_clk_50M,
  input  logic             cpu_rst_n,
  input  logic             start_i,
  input  logic             signed_i,
  input  logic             cancel_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             busy_o,
  output logic             ready_o,
  output logic             div_zero_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o
);

  localparam int c_ITER  = WIDTH / 2;
  localparam int c_CNT_W = $clog2(c_ITER) + 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ZERO = 3'd1,
    S_CALC = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic               r_pend;
  logic               r_signed;
  logic [WIDTH-1:0]   r_dvd_raw;
  logic [WIDTH-1:0]   r_dvs_raw;
  logic               r_dvd_neg;
  logic               r_dvs_neg;
  logic [WIDTH-1:0]   r_dvs_mag;
  logic [WIDTH-1:0]   r_quo;
  logic [WIDTH-1:0]   r_rem;
  logic [c_CNT_W-1:0] r_cnt;

  logic [WIDTH-1:0]   w_dvd_mag;
  logic [WIDTH-1:0]   w_dvs_mag;
  logic [WIDTH+2:0]   w_part;
  logic [WIDTH+2:0]   w_d1;
  logic [WIDTH+2:0]   w_d2;
  logic [WIDTH+2:0]   w_d3;
  logic [WIDTH+2:0]   w_t1;
  logic [WIDTH+2:0]   w_t2;
  logic [WIDTH+2:0]   w_t3;
  logic [1:0]         w_qbits;
  logic [WIDTH-1:0]   w_rem_nxt;

  assign w_dvd_mag = (r_signed && r_dvd_raw[WIDTH-1]) ? -r_dvd_raw : r_dvd_raw;
  assign w_dvs_mag = (r_signed && r_dvs_raw[WIDTH-1]) ? -r_dvs_raw : r_dvs_raw;

  // One radix-4 step: shift in two dividend bits, keep the largest non-negative trial.
  assign w_part = {1'b0, r_rem, r_quo[WIDTH-1:WIDTH-2]};
  assign w_d1   = {3'b000, r_dvs_mag};
  assign w_d2   = {2'b00, r_dvs_mag, 1'b0};
  assign w_d3   = w_d1 + w_d2;
  assign w_t1   = w_part - w_d1;
  assign w_t2   = w_part - w_d2;
  assign w_t3   = w_part - w_d3;

  always_comb begin
    w_qbits   = 2'd0;
    w_rem_nxt = w_part[WIDTH-1:0];
    if (!w_t3[WIDTH+2]) begin
      w_qbits   = 2'd3;
      w_rem_nxt = w_t3[WIDTH-1:0];
    end else if (!w_t2[WIDTH+2]) begin
      w_qbits   = 2'd2;
      w_rem_nxt = w_t2[WIDTH-1:0];
    end else if (!w_t1[WIDTH+2]) begin
      w_qbits   = 2'd1;
      w_rem_nxt = w_t1[WIDTH-1:0];
    end
  end

  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) r_state <= S_IDLE;
    else            r_state <= w_state_nxt;
  end

  // IDLE holds one extra cycle after capture (r_pend) to test the latched divisor.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (r_pend) w_state_nxt = (r_dvs_raw == '0) ? S_ZERO : S_CALC;
      S_ZERO: w_state_nxt = S_DONE;
      S_CALC: if (r_cnt == c_CNT_W'(c_ITER - 1)) w_state_nxt = S_FIX;
      S_FIX:  w_state_nxt = S_DONE;
      S_DONE: if (!start_i) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (cancel_i) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      r_pend      <= 1'b0;
      r_signed    <= 1'b0;
      r_dvd_raw   <= '0;
      r_dvs_raw   <= '0;
      r_dvd_neg   <= 1'b0;
      r_dvs_neg   <= 1'b0;
      r_dvs_mag   <= '0;
      r_quo       <= '0;
      r_rem       <= '0;
      r_cnt       <= '0;
      div_zero_o  <= 1'b0;
      quotient_o  <= '0;
      remainder_o <= '0;
    end else if (cancel_i) begin
      r_pend      <= 1'b0;
      div_zero_o  <= 1'b0;
      quotient_o  <= '0;
      remainder_o <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_pend) begin
            r_pend    <= 1'b0;
            r_cnt     <= '0;
            r_rem     <= '0;
            r_quo     <= w_dvd_mag;
            r_dvs_mag <= w_dvs_mag;
            r_dvd_neg <= r_signed & r_dvd_raw[WIDTH-1];
            r_dvs_neg <= r_signed & r_dvs_raw[WIDTH-1];
          end else if (start_i) begin
            r_pend    <= 1'b1;
            r_signed  <= signed_i;
            r_dvd_raw <= dividend_i;
            r_dvs_raw <= divisor_i;
          end
        end
        S_ZERO: begin
          div_zero_o  <= 1'b1;
          quotient_o  <= '1;
          remainder_o <= r_dvd_raw;
        end
        S_CALC: begin
          r_quo <= {r_quo[WIDTH-3:0], w_qbits};
          r_rem <= w_rem_nxt;
          r_cnt <= r_cnt + c_CNT_W'(1);
        end
        S_FIX: begin
          quotient_o  <= (r_dvd_neg ^ r_dvs_neg) ? -r_quo : r_quo;
          remainder_o <= r_dvd_neg ? -r_rem : r_rem;
        end
        S_DONE: begin
          if (!start_i) begin
            div_zero_o  <= 1'b0;
            quotient_o  <= '0;
            remainder_o <= '0;
          end
        end
        default: r_pend <= 1'b0;
      endcase
    end
  end

  assign busy_o  = (r_state == S_CALC) || (r_state == S_FIX);
  assign ready_o = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_div_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_div_unit : directed scoreboard bench for div_unit (WIDTH = 32).       |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module tb_div_unit;

  localparam int W = 32;

  logic         cpu_clk_50M = 1'b0;
  logic         cpu_rst_n   = 1'b0;
  logic         start_i     = 1'b0;
  logic         signed_i    = 1'b0;
  logic         cancel_i    = 1'b0;
  logic [W-1:0] dividend_i  = '0;
  logic [W-1:0] divisor_i   = '0;
  logic         busy_o;
  logic         ready_o;
  logic         div_zero_o;
  logic [W-1:0] quotient_o;
  logic [W-1:0] remainder_o;

  div_unit #(.WIDTH(W)) dut (
    .cpu_clk_50M (cpu_clk_50M),
    .cpu_rst_n   (cpu_rst_n),
    .start_i     (start_i),
    .signed_i    (signed_i),
    .cancel_i    (cancel_i),
    .dividend_i  (dividend_i),
    .divisor_i   (divisor_i),
    .busy_o      (busy_o),
    .ready_o     (ready_o),
    .div_zero_o  (div_zero_o),
    .quotient_o  (quotient_o),
    .remainder_o (remainder_o)
  );

  always #10 cpu_clk_50M = ~cpu_clk_50M;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
    int           lat;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference from language-level division; truncation toward zero gives dividend-signed remainders.
  function automatic exp_t model(input logic [W-1:0] dvd, input logic [W-1:0] dvs, input logic sgn);
    exp_t e;
    logic signed [W-1:0] sd;
    logic signed [W-1:0] sv;
    logic [W-1:0] most_neg;
    sd       = dvd;
    sv       = dvs;
    most_neg = {1'b1, {(W-1){1'b0}}};
    e.q = '0; e.r = '0; e.z = 1'b0; e.lat = W / 2 + 2;
    if (dvs == '0) begin
      e.q = '1; e.r = dvd; e.z = 1'b1; e.lat = 2;
    end else if (!sgn) begin
      e.q = dvd / dvs; e.r = dvd % dvs;
    end else if (dvd == most_neg && dvs == '1) begin
      e.q = most_neg; e.r = '0;
    end else begin
      e.q = sd / sv; e.r = sd % sv;
    end
    return e;
  endfunction

  task automatic wait_ready(output int n);
    n = 0;
    while (n < 40) begin
      @(posedge cpu_clk_50M); #1;
      n++;
      if (ready_o) break;
    end
  endtask

  task automatic run_op(input logic [W-1:0] dvd, input logic [W-1:0] dvs, input logic sgn,
                        input int toggle_at, input string tag);
    exp_t e;
    int   edges;
    int   busy_err;
    int   stab_err;
    sb.push_back(model(dvd, dvs, sgn));
    dividend_i = dvd; divisor_i = dvs; signed_i = sgn; start_i = 1'b1;
    @(posedge cpu_clk_50M); #1;
    dividend_i = ~dvd; divisor_i = dvs ^ 32'h5A5A_0001; signed_i = ~sgn;
    edges = 0; busy_err = 0;
    while (edges < 40) begin
      @(posedge cpu_clk_50M); #1;
      edges++;
      if (ready_o) break;
      if (busy_o !== !sb[0].z) busy_err++;
      if (edges == toggle_at)          start_i = 1'b0;
      else if (edges == toggle_at + 1) start_i = 1'b1;
    end
    e = sb.pop_front();
    chk({tag, " latency"}, W'(edges), W'(e.lat));
    chk({tag, " busy"}, W'(busy_err), '0);
    chk({tag, " quotient"}, quotient_o, e.q);
    chk({tag, " remainder"}, remainder_o, e.r);
    chk({tag, " div_zero"}, W'(div_zero_o), W'(e.z));
    stab_err = 0;
    repeat (10) begin
      @(posedge cpu_clk_50M); #1;
      if (quotient_o !== e.q || remainder_o !== e.r || ready_o !== 1'b1 || busy_o !== 1'b0) stab_err++;
    end
    chk({tag, " hold"}, W'(stab_err), '0);
    start_i = 1'b0;
    @(posedge cpu_clk_50M); #1;
    chk({tag, " release flags"}, W'({ready_o, div_zero_o, busy_o}), '0);
    chk({tag, " release data"}, quotient_o | remainder_o, '0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    #5;
    chk("reset flags", W'({ready_o, div_zero_o, busy_o}), '0);
    chk("reset data", quotient_o | remainder_o, '0);
    @(negedge cpu_clk_50M); cpu_rst_n = 1'b1;
    @(posedge cpu_clk_50M); #1;

    run_op(32'd100,       32'd7,         1'b1, 0, "s100/7");
    run_op(32'hFFFF_FFF9, 32'd2,         1'b1, 0, "s-7/2");
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, "smin/-1");
    run_op(32'hFFFF_FFFF, 32'd2,         1'b0, 0, "uffff/2");
    run_op(32'd5,         32'hFFFF_FFFF, 1'b0, 0, "u5/ffff");
    run_op(32'h0000_1234, 32'd0,         1'b0, 0, "zero");
    run_op(32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1, 5, "s-100/-7 toggle");
    run_op(32'd100,       32'hFFFF_FFF9, 1'b1, 0, "s100/-7");

    // cancel mid-CALC, with start still held high
    dividend_i = 32'd100; divisor_i = 32'd7; signed_i = 1'b1; start_i = 1'b1;
    @(posedge cpu_clk_50M); #1;
    repeat (5) @(posedge cpu_clk_50M);
    #1;
    chk("cancel pre busy", W'(busy_o), W'(1));
    cancel_i = 1'b1;
    @(posedge cpu_clk_50M); #1;
    chk("cancel flags", W'({ready_o, div_zero_o, busy_o}), '0);
    chk("cancel data", quotient_o | remainder_o, '0);
    cancel_i = 1'b0; start_i = 1'b0;
    @(posedge cpu_clk_50M); #1;
    run_op(32'd9, 32'd3, 1'b0, 0, "after cancel 9/3");

    // cancel from DONE clears held results
    dividend_i = 32'd50; divisor_i = 32'd5; signed_i = 1'b0; start_i = 1'b1;
    @(posedge cpu_clk_50M); #1;
    wait_ready(n);
    chk("done q 50/5", quotient_o, 32'd10);
    cancel_i = 1'b1;
    @(posedge cpu_clk_50M); #1;
    chk("cancel done flags", W'({ready_o, div_zero_o, busy_o}), '0);
    chk("cancel done data", quotient_o | remainder_o, '0);
    cancel_i = 1'b0; start_i = 1'b0;
    @(posedge cpu_clk_50M); #1;

    for (int i = 0; i < 4; i++) begin
      logic [W-1:0] a;
      logic [W-1:0] b;
      a = $urandom;
      b = $urandom >> $urandom_range(0, 28);
      run_op(a, b, 1'(i % 2), 0, "random");
    end

    // asynchronous reset while DONE
    dividend_i = 32'd77; divisor_i = 32'd5; signed_i = 1'b0; start_i = 1'b1;
    @(posedge cpu_clk_50M); #1;
    wait_ready(n);
    chk("done q 77/5", quotient_o, 32'd15);
    #3 cpu_rst_n = 1'b0;
    #1;
    chk("rst done flags", W'({ready_o, div_zero_o, busy_o}), '0);
    chk("rst done data", quotient_o | remainder_o, '0);
    start_i = 1'b0;
    @(negedge cpu_clk_50M); cpu_rst_n = 1'b1;
    @(posedge cpu_clk_50M); #1;

    // asynchronous reset mid-CALC
    dividend_i = 32'd1000; divisor_i = 32'd33; signed_i = 1'b0; start_i = 1'b1;
    @(posedge cpu_clk_50M); #1;
    repeat (5) @(posedge cpu_clk_50M);
    #1;
    chk("rst calc pre busy", W'(busy_o), W'(1));
    #4 cpu_rst_n = 1'b0;
    #1;
    chk("rst calc flags", W'({ready_o, div_zero_o, busy_o}), '0);
    chk("rst calc data", quotient_o | remainder_o, '0);
    start_i = 1'b0;
    @(negedge cpu_clk_50M); cpu_rst_n = 1'b1;
    @(posedge cpu_clk_50M); #1;
    run_op(32'd1000, 32'd33, 1'b0, 0, "after reset 1000/33");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
